// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pipeline_pkg
// Description : Shared pipeline word width, default encodings and IF/ID record.
// Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    localparam int          c_WORD_WIDTH = 32;
    localparam logic [31:0] c_NOP_INSTR  = 32'h0000_0000;
    localparam logic [31:0] c_RESET_PC   = 32'h0000_0000;

    typedef logic [c_WORD_WIDTH-1:0] word_t;

    typedef struct packed {
        word_t instr;
        word_t pcPlus1;
        logic  valid;
    } ifId_t;

    // A bubble carries the NOP encoding and is never marked as a real instruction.
    function automatic ifId_t makeBubble(input word_t nopInstr);
        ifId_t b;
        b.instr   = nopInstr;
        b.pcPlus1 = '0;
        b.valid   = 1'b0;
        return b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/etapa_fetch_pc_incrementer.sv
`default_nettype none
// ============================================================================
// Module      : pc_incrementer
// Description : Combinational word-address incrementer, wraps modulo 2^32.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_incrementer
    import pipeline_pkg::*;
(
    input  logic [c_WORD_WIDTH-1:0] pc,
    output logic [c_WORD_WIDTH-1:0] pcPlus1
);

    assign pcPlus1 = pc + c_WORD_WIDTH'(1);

endmodule
`default_nettype wire

// File: rtl/etapa_fetch.sv
`default_nettype none
// ============================================================================
// Module      : etapa_fetch
// Description : Instruction-fetch stage: PC register, next-PC priority mux and
//               IF/ID pipeline register. Define FETCH_COUNT_EN to add the
//               accepted-fetch counter output fetch_count.
// Revision    : 1.0 - initial release
// ============================================================================
module etapa_fetch
    import pipeline_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = c_RESET_PC,
    parameter logic [31:0] NOP_INSTR = c_NOP_INSTR
)(
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    stall,
    input  logic                    redirect,
    input  logic [c_WORD_WIDTH-1:0] redirect_pc,
    output logic [c_WORD_WIDTH-1:0] imem_addr,
    input  logic [c_WORD_WIDTH-1:0] imem_rdata,
    input  logic                    imem_ready,
    output logic [c_WORD_WIDTH-1:0] if_id_instr,
    output logic [c_WORD_WIDTH-1:0] if_id_pc_plus1,
    output logic                    if_id_valid
`ifdef FETCH_COUNT_EN
    ,
    output logic [c_WORD_WIDTH-1:0] fetch_count
`endif
);

    word_t r_pc;
    ifId_t r_ifId;
    word_t w_pcPlus1;
    logic  w_accept;

    pc_incrementer u_pcInc (
        .pc      (r_pc),
        .pcPlus1 (w_pcPlus1)
    );

    // An instruction is accepted only when nothing of higher priority intervenes.
    assign w_accept = !redirect && !stall && imem_ready;

    // Redirect beats stall: whatever ID holds is wrong-path once EX redirects.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc   <= RESET_PC;
            r_ifId <= makeBubble(NOP_INSTR);
        end else if (redirect) begin
            r_pc   <= redirect_pc;
            r_ifId <= makeBubble(NOP_INSTR);
        end else if (stall) begin
            r_pc   <= r_pc;
            r_ifId <= r_ifId;
        end else if (!imem_ready) begin
            r_pc   <= r_pc;
            r_ifId <= makeBubble(NOP_INSTR);
        end else begin
            r_pc           <= w_pcPlus1;
            r_ifId.instr   <= imem_rdata;
            r_ifId.pcPlus1 <= w_pcPlus1;
            r_ifId.valid   <= 1'b1;
        end
    end

    assign imem_addr      = r_pc;
    assign if_id_instr    = r_ifId.instr;
    assign if_id_pc_plus1 = r_ifId.pcPlus1;
    assign if_id_valid    = r_ifId.valid;

`ifdef FETCH_COUNT_EN
    word_t r_fetchCount;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fetchCount <= '0;
        end else if (w_accept) begin
            r_fetchCount <= r_fetchCount + c_WORD_WIDTH'(1);
        end
    end

    assign fetch_count = r_fetchCount;
`endif

endmodule
`default_nettype wire

// File: tb/tb_etapa_fetch.sv
`default_nettype none
// ============================================================================
// Module      : tb_etapa_fetch
// Description : Self-checking bench for etapa_fetch: directed scenarios plus
//               randomized traffic against a behavioural fetch model.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_etapa_fetch;

    localparam logic [31:0] c_NOP  = 32'h0000_0000;
    localparam logic [31:0] c_RPC  = 32'h0000_0000;
    localparam logic [31:0] c_OFFS = 32'h0000_A000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic        imem_ready = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic [31:0] if_id_instr;
    logic [31:0] if_id_pc_plus1;
    logic        if_id_valid;
`ifdef FETCH_COUNT_EN
    logic [31:0] fetch_count;
`endif

    // Model of the fetch stage: architectural PC plus the IF/ID contents.
    logic [31:0] mPc = c_RPC;
    logic [31:0] mInstr = c_NOP;
    logic [31:0] mP1 = '0;
    logic        mValid = 1'b0;
    logic [31:0] mCount = '0;

    int nChecks = 0;
    int nPass = 0;

    logic [96:0] w_act;

    always #5 clk = ~clk;

    // Memory contents: each word holds its own address plus a fixed offset.
    assign imem_rdata = imem_addr + c_OFFS;
    assign w_act = {imem_addr, if_id_instr, if_id_pc_plus1, if_id_valid};

    etapa_fetch dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .imem_ready     (imem_ready),
        .if_id_instr    (if_id_instr),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid)
`ifdef FETCH_COUNT_EN
        ,
        .fetch_count    (fetch_count)
`endif
    );

    function automatic logic [96:0] expVec();
        return {mPc, mInstr, mP1, mValid};
    endfunction

    task automatic modelReset();
        mPc = c_RPC; mInstr = c_NOP; mP1 = '0; mValid = 1'b0; mCount = '0;
    endtask

    // Advance one clock; the model consumes the inputs that were present at the edge.
    task automatic tick();
        if (!rst_n) begin
            modelReset();
        end else if (redirect) begin
            mPc = redirect_pc; mInstr = c_NOP; mP1 = '0; mValid = 1'b0;
        end else if (stall) begin
            mPc = mPc;
        end else if (!imem_ready) begin
            mInstr = c_NOP; mP1 = '0; mValid = 1'b0;
        end else begin
            mInstr = mPc + c_OFFS; mP1 = mPc + 32'd1; mValid = 1'b1;
            mPc = mPc + 32'd1; mCount = mCount + 32'd1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; imem_ready = 1'b1;
        repeat (3) tick();
        nChecks++;
        if (w_act !== {32'd0, c_NOP, 32'd0, 1'b0})
            $display("FAIL reset_state: got %h want %h", w_act, {32'd0, c_NOP, 32'd0, 1'b0});
        else nPass++;
        rst_n = 1'b1;
        nChecks++;
        if (imem_addr !== 32'd0) $display("FAIL run_addr0: got %h want %h", imem_addr, 32'd0);
        else nPass++;
        tick();
        nChecks++;
        if (w_act !== {32'd1, 32'hA000, 32'd1, 1'b1})
            $display("FAIL first_fetch: got %h want %h", w_act, {32'd1, 32'hA000, 32'd1, 1'b1});
        else nPass++;
        for (int i = 2; i <= 3; i++) begin
            tick();
            nChecks++;
            if (imem_addr !== 32'(i)) $display("FAIL run_addr%0d: got %h want %h", i, imem_addr, 32'(i));
            else nPass++;
        end
    endtask

    task automatic test_stall();
        repeat (2) tick();
        stall = 1'b1;
        for (int i = 0; i < 2; i++) begin
            tick();
            nChecks++;
            if (w_act !== {32'd5, 32'hA004, 32'd5, 1'b1})
                $display("FAIL stall_hold%0d: got %h want %h", i, w_act, {32'd5, 32'hA004, 32'd5, 1'b1});
            else nPass++;
        end
        stall = 1'b0;
        tick();
        nChecks++;
        if (imem_addr !== 32'd6) $display("FAIL stall_release: got %h want %h", imem_addr, 32'd6);
        else nPass++;
    endtask

    task automatic test_redirect_stall();
        repeat (2) tick();
        redirect = 1'b1; redirect_pc = 32'h40; stall = 1'b1;
        tick();
        redirect = 1'b0; stall = 1'b0;
        nChecks++;
        if (w_act !== {32'h40, c_NOP, 32'd0, 1'b0})
            $display("FAIL redirect_stall: got %h want %h", w_act, {32'h40, c_NOP, 32'd0, 1'b0});
        else nPass++;
    endtask

    task automatic test_wait();
        redirect = 1'b1; redirect_pc = 32'd3;
        tick();
        redirect = 1'b0; imem_ready = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            nChecks++;
            if ({imem_addr, if_id_valid} !== {32'd3, 1'b0})
                $display("FAIL wait%0d: got %h/%b want 3/0", i, imem_addr, if_id_valid);
            else nPass++;
        end
        imem_ready = 1'b1;
        tick();
        nChecks++;
        if (w_act !== {32'd4, 32'hA003, 32'd4, 1'b1})
            $display("FAIL wait_resume: got %h want %h", w_act, {32'd4, 32'hA003, 32'd4, 1'b1});
        else nPass++;
    endtask

    task automatic test_wrap_async_reset();
        redirect = 1'b1; redirect_pc = 32'hFFFF_FFFF;
        tick();
        redirect = 1'b0;
        tick();
        nChecks++;
        if (w_act !== {32'd0, 32'h0000_9FFF, 32'd0, 1'b1})
            $display("FAIL wrap: got %h want %h", w_act, {32'd0, 32'h0000_9FFF, 32'd0, 1'b1});
        else nPass++;
        #3;
        rst_n = 1'b0;
        #1;
        nChecks++;
        if (w_act !== {c_RPC, c_NOP, 32'd0, 1'b0})
            $display("FAIL async_reset: got %h want %h", w_act, {c_RPC, c_NOP, 32'd0, 1'b0});
        else nPass++;
        modelReset();
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            redirect    = ($urandom_range(0, 7) == 0);
            redirect_pc = ($urandom_range(0, 3) == 0) ? $urandom() : 32'($urandom_range(0, 64));
            stall       = ($urandom_range(0, 4) == 0);
            imem_ready  = ($urandom_range(0, 3) != 0);
            tick();
            nChecks++;
            if (w_act !== expVec())
                $display("FAIL random%0d: got %h want %h", i, w_act, expVec());
            else nPass++;
`ifdef FETCH_COUNT_EN
            nChecks++;
            if (fetch_count !== mCount)
                $display("FAIL random_count%0d: got %0d want %0d", i, fetch_count, mCount);
            else nPass++;
`endif
        end
        redirect = 1'b0; stall = 1'b0; imem_ready = 1'b1;
    endtask

`ifdef FETCH_COUNT_EN
    task automatic test_count();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1; imem_ready = 1'b1;
        repeat (5) tick();
        stall = 1'b1; tick(); stall = 1'b0;
        imem_ready = 1'b0; tick(); imem_ready = 1'b1;
        redirect = 1'b1; redirect_pc = 32'h100; tick(); redirect = 1'b0;
        nChecks++;
        if (fetch_count !== 32'd5) $display("FAIL fetch_count: got %0d want 5", fetch_count);
        else nPass++;
    endtask
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stall();
        test_redirect_stall();
        test_wait();
        test_wrap_async_reset();
        test_random();
`ifdef FETCH_COUNT_EN
        test_count();
`endif
        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

endmodule
`default_nettype wire
